// File: rtl/snell_pkg.sv
// Shared constants for the snell_law datapath multiplier and its sequencers.
package snell_pkg;

    localparam int unsigned MUL_XW = 9;
    localparam int unsigned MUL_YW = 4;
    localparam int unsigned MUL_PW = 13;

    // Bits needed to encode n distinct values; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wallace_tree_multiplier.sv
// Unsigned 9x4 multiplier: carry-save reduction of four partial products,
// final add, then LAT output registers.
module wallace_tree_multiplier
    import snell_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic              clk,
    input  logic [MUL_XW-1:0] x,
    input  logic [MUL_YW-1:0] y,
    output logic [MUL_PW-1:0] product
);

    logic [MUL_PW-1:0] pp [MUL_YW];
    logic [MUL_PW-1:0] s1, c1, s2, c2, sum;
    logic [MUL_PW-1:0] pipe_q [LAT];

    always_comb begin
        for (int j = 0; j < int'(MUL_YW); j++) begin
            pp[j] = MUL_PW'(x & {MUL_XW{y[j]}}) << j;
        end
        s1  = pp[0] ^ pp[1] ^ pp[2];
        c1  = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
        s2  = s1 ^ c1 ^ pp[3];
        c2  = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
        sum = s2 + c2;
    end

    // No reset: stale contents are masked by the caller's tag valid bits.
    always_ff @(posedge clk) begin
        pipe_q[0] <= sum;
        for (int i = 1; i < int'(LAT); i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign product = pipe_q[LAT-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one wallace_tree_multiplier among NREQ requesters,
// with a tag pipeline returning each product alongside its requester ID.
module mult_share_arbiter
    import snell_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned MUL_LAT = 1,
    localparam int unsigned IdW     = clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*MUL_XW-1:0] req_x,
    input  logic [NREQ*MUL_YW-1:0] req_y,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IdW-1:0]         rsp_id,
    output logic [MUL_PW-1:0]      rsp_product,
    output logic                   busy
);

    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d, grant_id;
    logic              xfer;
    logic [MUL_XW-1:0] opx_q, opx_d;
    logic [MUL_YW-1:0] opy_q, opy_d;
    logic [MUL_LAT:0]  tag_vld_q;
    logic [IdW-1:0]    tag_id_q [MUL_LAT+1];
    logic [MUL_PW-1:0] product;

    always_comb begin
        int unsigned    idx;
        logic [IdW-1:0] idx_id;
        req_ready = '0;
        grant_id  = '0;
        xfer      = 1'b0;
        idx       = 0;
        idx_id    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_id = IdW'(idx);
            if (!xfer && req_valid[idx_id]) begin
                xfer              = 1'b1;
                req_ready[idx_id] = 1'b1;
                grant_id          = idx_id;
            end
        end
    end

    always_comb begin
        int unsigned nxt;
        nxt = 32'(grant_id) + 1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        rr_ptr_d = xfer ? IdW'(nxt) : rr_ptr_q;
        opx_d    = xfer ? req_x[32'(grant_id)*MUL_XW +: MUL_XW] : opx_q;
        opy_d    = xfer ? req_y[32'(grant_id)*MUL_YW +: MUL_YW] : opy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            opx_q     <= '0;
            opy_q     <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i <= int'(MUL_LAT); i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            tag_vld_q   <= {tag_vld_q[MUL_LAT-1:0], xfer};
            tag_id_q[0] <= grant_id;
            for (int i = 1; i <= int'(MUL_LAT); i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    wallace_tree_multiplier #(
        .LAT(MUL_LAT)
    ) u_mul (
        .clk    (clk),
        .x      (opx_q),
        .y      (opy_q),
        .product(product)
    );

    assign rsp_valid   = tag_vld_q[MUL_LAT];
    assign rsp_id      = tag_id_q[MUL_LAT];
    assign rsp_product = rsp_valid ? product : '0;
    assign busy        = |tag_vld_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a queue-based response model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_mult_share_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*9-1:0] req_x;
    logic [NREQ*4-1:0] req_y;
    logic [NREQ-1:0] req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [12:0]     rsp_product;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [NREQ-1:0] g;

    typedef struct {
        int issue;
        int due;
        int id;
        int prod;
    } op_t;

    op_t q[$];
    int  m_rr = 0;

    mult_share_arbiter #(
        .NREQ   (NREQ),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr + k) % NREQ;
            if (v[idx]) return NREQ'(1 << idx);
        end
        return '0;
    endfunction

    // Model: the spec's round-robin rule plus a FIFO of products due at
    // issue + 1 + MUL_LAT.
    always @(negedge clk) begin : model
        logic [NREQ-1:0] mg;
        int              gi;
        op_t             e;
        logic            exp_v;
        mg = model_grant(req_valid, m_rr);
        chk("model_ready", 32'(req_ready), 32'(mg));
        if (rst) begin
            q.delete();
            m_rr = 0;
        end
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        chk("model_rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("model_rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("model_rsp_product", 32'(rsp_product), 32'(q[0].prod));
        end else begin
            chk("model_rsp_product_idle", 32'(rsp_product), 32'd0);
        end
        chk("model_busy", 32'(busy), 32'((q.size() > 0) && (q[0].issue < cyc)));
        if (exp_v) void'(q.pop_front());
        if (!rst && mg != '0) begin
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (mg[i]) gi = i;
            e.issue = cyc;
            e.due   = cyc + 1 + MUL_LAT;
            e.id    = gi;
            e.prod  = int'(req_x[gi*9 +: 9]) * int'(req_y[gi*4 +: 4]);
            q.push_back(e);
            m_rr = (gi + 1) % NREQ;
        end
    end

    task automatic set_req(input int i, input int x, input int y);
        req_valid[i]     = 1'b1;
        req_x[i*9 +: 9]  = 9'(x);
        req_y[i*4 +: 4]  = 4'(y);
    endtask

    // half(): move to the sampling point of the current cycle.
    // adv(): move to just after the next edge; granted requesters drop valid.
    task automatic half();
        @(negedge clk);
        g = req_ready & req_valid;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g;
        g = '0;
    endtask

    task automatic single_op(input int i, input int x, input int y, input int p);
        set_req(i, x, y);
        half();
        chk("op_ready", 32'(req_ready), 32'(1 << i));
        adv();
        half();
        chk("op_busy", 32'(busy), 32'd1);
        adv();
        half();
        chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("op_rsp_id", 32'(rsp_id), 32'(i));
        chk("op_rsp_product", 32'(rsp_product), 32'(p));
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit %0d", 100000);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        g         = '0;
        #1;
        half();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_product", 32'(rsp_product), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        adv();
        rst = 1'b0;

        single_op(0, 300, 10, 3000);
        half();
        chk("single_busy_drop", 32'(busy), 32'd0);
        adv();
        single_op(3, 7, 3, 21);
        half();
        adv();

        // Pointer is 0 here: grants 0..3, responses two cycles behind.
        for (int j = 0; j < NREQ; j++) set_req(j, j + 1, 5);
        for (int k = 0; k < 6; k++) begin
            half();
            if (k < 4) chk("cont_ready", 32'(req_ready), 32'(1 << k));
            if (k >= 2) begin
                chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("cont_rsp_id", 32'(rsp_id), 32'(k - 2));
                chk("cont_rsp_product", 32'(rsp_product), 32'(5 * (k - 1)));
            end
            adv();
        end

        single_op(2, 2, 2, 4);
        set_req(1, 9, 9);
        set_req(3, 10, 10);
        half();
        chk("fair_first", 32'(req_ready), 32'b1000);
        adv();
        half();
        chk("fair_second", 32'(req_ready), 32'b0010);
        adv();

        single_op(3, 1, 1, 1);
        set_req(0, 3, 3);
        set_req(1, 4, 4);
        half();
        chk("wrap_first", 32'(req_ready), 32'b0001);
        adv();
        half();
        chk("wrap_second", 32'(req_ready), 32'b0010);
        adv();

        single_op(1, 511, 15, 7665);
        single_op(2, 0, 15, 0);
        single_op(3, 511, 0, 0);
        repeat (3) begin
            half();
            adv();
        end

        // Two ops in flight, then reset before either responds.
        set_req(0, 100, 2);
        set_req(1, 50, 3);
        half();
        adv();
        half();
        adv();
        rst = 1'b1;
        half();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        adv();
        rst = 1'b0;
        set_req(1, 6, 6);
        set_req(3, 8, 8);
        half();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'b0010);
        adv();
        half();
        chk("post_rst_ready2", 32'(req_ready), 32'b1000);
        adv();
        single_op(0, 300, 10, 3000);
        repeat (4) begin
            half();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one `wallace_tree_multiplier` (9-bit × 4-bit → 13-bit) among several requesters in the snell_law datapath. It accepts at most one operand pair per cycle through a valid/ready handshake and drives the registered operands into the multiplier. It tags every operation with its requester ID and returns each product with that tag after a fixed latency.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 1: registered latency of `wallace_tree_multiplier`, in cycles from operand to `product`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in NREQ: request i presents an operand pair.
- `req_x` in NREQ*9: operand x of requester i, in bits [9i+8:9i].
- `req_y` in NREQ*4: operand y of requester i, in bits [4i+3:4i].
- `req_ready` in→out NREQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: product valid this cycle; single-cycle pulse per operation.
- `rsp_id` out clog2(NREQ): ID of the requester that owns `rsp_product`.
- `rsp_product` out 13: x*y, unsigned.
- `busy` out 1: at least one operation is in flight.

## Operation
- Arbitration: combinational round-robin from pointer `rr_ptr`.
  - Grant the first i with `req_valid[i]`, scanning `rr_ptr, rr_ptr+1, …` modulo NREQ.
  - `req_ready` is the one-hot grant; it is all-zero when no request is valid.
  - After a transfer by i, `rr_ptr` ← (i+1) mod NREQ. With no transfer, `rr_ptr` holds.
  - A requester holds `req_valid` and its operands stable until it sees ready; the block never drops a request silently.
- Issue: on a transfer, `opx/opy` registers capture the granted operands, and tag stage 0 captures {1, id}. With no transfer, tag stage 0 captures {0, x}, and `opx/opy` hold their values; the values are don't-care.
- Tag pipeline: MUL_LAT+1 stages of {valid, id}, aligned with `opx/opy` → multiplier → `product`.
  - `rsp_valid/rsp_id` come from the last tag stage.
  - `rsp_product` = multiplier `product` and is 0 whenever `rsp_valid`=0.
- Width rules:
  - Unsigned arithmetic. The maximum 511×15 = 7665 fits in 13 bits, so there is no overflow.
  - `req_x` and `req_y` are sliced per requester; there is no sign extension.
- No response backpressure: the consumer accepts every `rsp_valid` pulse. Throughput is one op/cycle.
- `busy` = OR of all tag-stage valid bits.

## Timing
- Reset values: `rr_ptr`=0, all tag valids=0, `opx`=0, `opy`=0. Outputs `req_ready` = grant of current inputs, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0.
- Latency: a transfer in cycle t gives `rsp_valid` in cycle t+1+MUL_LAT, which is cycle t+2 for the default.
- Back-to-back transfers in consecutive cycles give responses in consecutive cycles, in issue order.
- Simultaneous requests: exactly one grant per cycle. Requester i waits at most NREQ−1 cycles while it holds valid.
- Pointer wrap: a grant to NREQ−1 sets `rr_ptr`=0.
- Reset mid-operation: all in-flight tags are cleared immediately, so no response is emitted for operations accepted before reset. The multiplier's internal registers may hold stale data, which is masked by the tag valid bits. The first grant after release goes to the lowest valid index.
- `req_valid` deasserted while not granted: legal; nothing is issued.

## Structure
- Shared package `snell_pkg`: constants `MUL_XW`=9, `MUL_YW`=4, `MUL_PW`=13, and function `clog2`.
- One sub-module: the existing `wallace_tree_multiplier` (ports `x`, `y`, `clk`, `product`), instantiated once.
- The arbiter, pointer, operand registers and tag pipeline are local to this block.

## Test plan
- Single request: req 0 sends x=300, y=10 at cycle t. Expect `req_ready`=0001 at t; at t+2, `rsp_valid`=1, `rsp_id`=0, `rsp_product`=3000; `busy` high t+1..t+2.
- Contention: all four valid, with x=1..4 and y=5 from t. Expect grants 0,1,2,3 on t..t+3, then responses 5,10,15,20 with IDs 0..3 on t+2..t+5.
- Fairness: `rr_ptr`=3 (after a grant to 2), with requests 1 and 3 valid. Expect a grant to 3 first, then 1. Then `rr_ptr` wraps and 0 wins next.
- Boundaries: x=511,y=15 gives 7665; x=0,y=15 gives 0; x=511,y=0 gives 0. All arrive at t+2 with the correct IDs.
- Reset mid-flight: issue two ops, then assert `rst` one cycle later. Expect no `rsp_valid` afterward, `busy`=0 and `rr_ptr`=0. Immediately after release, a new op x=300,y=10 returns 3000.
